// File: rtl/chargen_seq.sv
// Character-generator sequencer: fixed-length rotating printable ASCII lines terminated by CR LF.
// Latency: 1 cycle from en_n sampled low in IDLE to the first byte offer; back-to-back bytes with no bubbles.
// Backpressure: ready_n high holds valid_n, data and state; en_n only acts in IDLE and on the LF transfer edge.
module chargen_seq #(
    parameter int         LINE_LEN = 72,
    parameter logic [7:0] FIRST    = 8'h20,
    parameter logic [7:0] LAST     = 8'h7E
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        en_n,
    output logic        valid_n,
    input  logic        ready_n,
    output logic [7:0]  data,
    output logic        busy_n,
    output logic [15:0] line_no
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CHAR = 2'd1;
    localparam logic [1:0] S_CR   = 2'd2;
    localparam logic [1:0] S_LF   = 2'd3;

    localparam logic [7:0] COL_LAST = 8'(LINE_LEN - 1);

    logic [1:0]  state, state_nx;
    logic [7:0]  col, col_nx;
    logic [7:0]  cur, cur_nx;
    logic [7:0]  start, start_nx;
    logic [15:0] line_nx;
    logic [7:0]  data_nx;
    logic        xfer;

    function automatic logic [7:0] rot(input logic [7:0] x);
        return (x == LAST) ? FIRST : x + 8'd1;
    endfunction

    assign xfer = !valid_n && !ready_n;

    always_comb begin
        state_nx = state;
        col_nx   = col;
        cur_nx   = cur;
        start_nx = start;
        line_nx  = line_no;
        case (state)
            S_IDLE: begin
                if (!en_n) begin
                    state_nx = S_CHAR;
                    cur_nx   = start;
                    col_nx   = 8'd0;
                end
            end
            S_CHAR: begin
                if (xfer) begin
                    if (col == COL_LAST) begin
                        state_nx = S_CR;
                    end else begin
                        cur_nx = rot(cur);
                        col_nx = col + 8'd1;
                    end
                end
            end
            S_CR: begin
                if (xfer) state_nx = S_LF;
            end
            default: begin
                if (xfer) begin
                    start_nx = rot(start);
                    line_nx  = line_no + 16'd1;
                    // Continuing straight into the next line keeps the stream bubble-free.
                    if (!en_n) begin
                        state_nx = S_CHAR;
                        cur_nx   = rot(start);
                        col_nx   = 8'd0;
                    end else begin
                        state_nx = S_IDLE;
                    end
                end
            end
        endcase
    end

    always_comb begin
        case (state_nx)
            S_CR:    data_nx = 8'h0D;
            S_LF:    data_nx = 8'h0A;
            default: data_nx = cur_nx;
        endcase
    end

    // Outputs are registered from next-state values so the new byte appears on the transfer edge.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state   <= S_IDLE;
            col     <= 8'd0;
            cur     <= FIRST;
            start   <= FIRST;
            line_no <= 16'd0;
            data    <= FIRST;
            valid_n <= 1'b1;
            busy_n  <= 1'b1;
        end else begin
            state   <= state_nx;
            col     <= col_nx;
            cur     <= cur_nx;
            start   <= start_nx;
            line_no <= line_nx;
            data    <= data_nx;
            valid_n <= (state_nx == S_IDLE);
            busy_n  <= (state_nx == S_IDLE);
        end
    end

endmodule

// File: tb/tb_chargen_seq.sv
// Bench for chargen_seq: reset/start vector table, then model-checked line scenarios and a UART framing check.
module tb_chargen_seq;

    localparam int         LL    = 72;
    localparam int         NROT  = 95;
    localparam logic [7:0] FIRST = 8'h20;
    localparam int         LINE  = LL + 2;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        en_n = 1'b1;
    logic        ready_n = 1'b1;
    logic        valid_n;
    logic [7:0]  data;
    logic        busy_n;
    logic [15:0] line_no;

    chargen_seq dut (
        .clk(clk), .n_rst(n_rst), .en_n(en_n), .valid_n(valid_n),
        .ready_n(ready_n), .data(data), .busy_n(busy_n), .line_no(line_no)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // Reference model: a line is LL rotating characters then CR LF; line k starts k steps into the rotation.
    bit   m_active;
    int   m_pos;
    int   m_lines;
    int   n_xfer;
    logic [7:0] got[$];

    typedef struct {
        logic       rst;
        logic       en;
        logic       rdy;
        logic       e_valid;
        logic [7:0] e_data;
        logic       e_busy;
        logic [15:0] e_line;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input int ln, input int p);
        if (p < LL) return FIRST + 8'((ln + p) % NROT);
        else if (p == LL) return 8'h0D;
        else return 8'h0A;
    endfunction

    task automatic do_reset(input logic e, input logic r);
        n_rst = 1'b0; en_n = e; ready_n = r;
        @(posedge clk); #1;
        m_active = 0; m_pos = 0; m_lines = 0;
        chk("rst_valid_n", valid_n, 1'b1);
        chk("rst_busy_n", busy_n, 1'b1);
        chk("rst_line_no", line_no, 16'd0);
        chk("rst_data", data, FIRST);
        n_rst = 1'b1; en_n = 1'b1; ready_n = 1'b1;
        got.delete();
    endtask

    task automatic step(input logic e, input logic r);
        logic       pv;
        logic [7:0] pd;
        bit         mx;
        en_n = e; ready_n = r;
        pv = valid_n; pd = data;
        mx = m_active && !r;
        if (mx) begin
            got.push_back(pd);
            n_xfer++;
        end
        @(posedge clk);
        if (!m_active) begin
            if (!e) begin m_active = 1; m_pos = 0; end
        end else if (mx) begin
            m_pos++;
            if (m_pos == LINE) begin
                m_pos = 0;
                m_lines++;
                m_active = !e;
            end
        end
        #1;
        chk("valid_n", valid_n, !m_active);
        chk("busy_n", busy_n, !m_active);
        chk("line_no", line_no, m_lines[15:0]);
        if (m_active) chk("data", data, exp_byte(m_lines, m_pos));
        if (!pv && r) chk("stall_hold", data, pd);
    endtask

    initial begin
        vec_t vt[11];
        int   k;
        vt[0]  = '{1'b0, 1'b1, 1'b1, 1'b1, 8'h20, 1'b1, 16'd0};
        vt[1]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h20, 1'b1, 16'd0};
        vt[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h20, 1'b0, 16'd0};
        vt[3]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h20, 1'b0, 16'd0};
        vt[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h21, 1'b0, 16'd0};
        vt[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h22, 1'b0, 16'd0};
        vt[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h22, 1'b0, 16'd0};
        vt[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h20, 1'b1, 16'd0};
        vt[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h20, 1'b0, 16'd0};
        vt[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h21, 1'b0, 16'd0};
        vt[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'h20, 1'b1, 16'd0};
        for (int i = 0; i < 11; i++) begin
            n_rst = vt[i].rst; en_n = vt[i].en; ready_n = vt[i].rdy;
            @(posedge clk); #1;
            chk($sformatf("vec%0d_valid_n", i), valid_n, vt[i].e_valid);
            chk($sformatf("vec%0d_data", i), data, vt[i].e_data);
            chk($sformatf("vec%0d_busy_n", i), busy_n, vt[i].e_busy);
            chk($sformatf("vec%0d_line_no", i), line_no, vt[i].e_line);
        end

        // One line, ready held low: 74 transfers in 74 cycles.
        do_reset(1'b1, 1'b1);
        step(1'b0, 1'b0);
        n_xfer = 0;
        for (int i = 0; i < LINE; i++) step(1'b1, 1'b0);
        chk("l1_xfers", n_xfer, LINE);
        chk("l1_first", got[0], 8'h20);
        chk("l1_last_char", got[LL-1], 8'h67);
        chk("l1_cr", got[LL], 8'h0D);
        chk("l1_lf", got[LL+1], 8'h0A);
        chk("l1_line_no", line_no, 16'd1);

        // 96 continuous lines through the rotation wrap.
        do_reset(1'b1, 1'b1);
        step(1'b0, 1'b0);
        for (int i = 0; i < 96 * LINE; i++) step(i == 96 * LINE - 1, 1'b0);
        chk("run_count", got.size(), 96 * LINE);
        chk("run_l1_start", got[LINE], 8'h21);
        chk("run_l94_start", got[94 * LINE], 8'h7E);
        chk("run_l94_wrap", got[94 * LINE + 1], 8'h20);
        chk("run_l95_start", got[95 * LINE], 8'h20);
        chk("run_line_no", line_no, 16'd96);
        chk("run_idle", valid_n, 1'b1);

        // Random stalls must not change the byte sequence.
        do_reset(1'b1, 1'b1);
        step(1'b0, 1'b1);
        k = 0;
        while (m_lines == 0 && k < 3000) begin
            step(1'b1, ($urandom_range(99) < 30) ? 1'b1 : 1'b0);
            k++;
        end
        chk("stall_timeout", k < 3000, 1'b1);
        chk("stall_count", got.size(), LINE);
        for (int i = 0; i < got.size() && i < LINE; i++)
            chk($sformatf("stall_seq%0d", i), got[i], exp_byte(0, i));

        // Deassert enable mid-line: the line still completes, then resumes the rotation.
        do_reset(1'b1, 1'b1);
        step(1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0);
        k = 0;
        while (valid_n == 1'b0 && k < 200) begin
            step(1'b1, 1'b0);
            k++;
        end
        chk("stop_timeout", k < 200, 1'b1);
        chk("stop_last", got[got.size()-1], 8'h0A);
        chk("stop_busy_n", busy_n, 1'b1);
        chk("stop_line_no", line_no, 16'd1);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        chk("resume_first", data, 8'h21);

        // Reset coincident with a transfer mid-line abandons the line.
        do_reset(1'b1, 1'b1);
        step(1'b0, 1'b0);
        for (int i = 0; i < 2 * LINE + 40; i++) step(1'b0, 1'b0);
        chk("pre_rst_line_no", line_no, 16'd2);
        do_reset(1'b0, 1'b0);
        step(1'b0, 1'b0);
        chk("post_rst_first", data, 8'h20);

        // Transmitter model at two cycles per bit, loading on its final stop-bit cycle.
        begin
            bit         ubusy;
            int         bi, cnt, loads;
            logic [9:0] sh;
            bit         started, req, v;
            logic [7:0] d, dec;
            bit         txq[$];
            do_reset(1'b1, 1'b1);
            ubusy = 0; bi = 0; cnt = 0; loads = 0; started = 0; sh = '1;
            for (int c = 0; c < 300 && txq.size() < 60; c++) begin
                req = !ubusy || (bi == 9 && cnt == 1);
                if (started) txq.push_back(ubusy ? sh[bi] : 1'b1);
                v = (valid_n == 1'b0);
                d = data;
                if (loads > 0 && loads < 3 && req) chk("uart_no_gap", v, 1'b1);
                step(1'b0, (loads < 3 && req) ? 1'b0 : 1'b1);
                if (loads < 3 && req && v) begin
                    sh = {1'b1, d, 1'b0}; ubusy = 1; bi = 0; cnt = 0;
                    loads++; started = 1;
                end else if (ubusy) begin
                    cnt++;
                    if (cnt == 2) begin
                        cnt = 0; bi++;
                        if (bi == 10) ubusy = 0;
                    end
                end
            end
            chk("uart_bits", txq.size(), 60);
            for (int f = 0; f < 3 && txq.size() >= 60; f++) begin
                for (int b = 0; b < 8; b++) dec[b] = txq[f * 20 + 2 + 2 * b];
                chk($sformatf("uart_start%0d", f), txq[f * 20], 1'b0);
                chk($sformatf("uart_byte%0d", f), dec, 8'h20 + 8'(f));
                chk($sformatf("uart_stop%0d", f), txq[f * 20 + 18], 1'b1);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/chargen_seq.md
# chargen_seq

RFC 864-style character-generator sequencer that drives the byte-serial UART transmitter (`uartout`) through its active-low valid/ready handshake. It emits fixed-length lines of rotating printable ASCII, each terminated by CR LF, and starts or stops only on line boundaries under an active-low enable. It sits between the top-level control logic and `uartout`, acting as the transmitter's byte-stream scheduler.

## Interface
- `LINE_LEN`, 72: printable characters per line, before CR LF; legal range 1..255.
- `FIRST`, 8'h20: lowest character in the rotation (space).
- `LAST`, 8'h7E: highest character in the rotation (`~`); must be greater than `FIRST`.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `n_rst`  in  1  reset, synchronous, active-low.
- `en_n`  in  1  run request, active-low level.
- `valid_n`  out  1  byte offer to `uartout`, active-low.
- `ready_n`  in  1  `uartout` can accept, active-low.
- `data`  out  8  byte offered to `uartout`.
- `busy_n`  out  1  low while a line is in progress (any state other than IDLE).
- `line_no`  out  16  count of completed lines since reset; wraps modulo 2^16.

## Operation
- Transfer rule: a byte moves on a rising edge where `valid_n`=0 and `ready_n`=0. While `valid_n`=0 and no transfer occurs, `data` holds stable.
- `valid_n` is never withdrawn before its transfer completes.
- States:
  - IDLE: `valid_n`=1.
  - CHAR: offering rotating characters.
  - CR: offering 8'h0D.
  - LF: offering 8'h0A.
- Registers:
  - `col`, 8 bits: position within the current line.
  - `cur`, 8 bits: character being offered.
  - `start`, 8 bits: first character of the current line.
- Rotation: next(x) = (x == `LAST`) ? `FIRST` : x+1.
- IDLE → CHAR on an edge with `en_n`=0. On that edge: `cur`←`start`, `col`←0.
- CHAR, on a transfer:
  - If `col` == `LINE_LEN`-1: go to CR.
  - Otherwise: `cur`←next(`cur`), `col`←`col`+1.
- CR → LF on a transfer.
- LF, on a transfer:
  - `start`←next(`start`).
  - `line_no`←`line_no`+1.
  - If `en_n`=0 on that edge: go to CHAR with `cur`←next(old `start`) and `col`←0.
  - Otherwise: go to IDLE.
- `en_n` is ignored outside IDLE and the LF transfer edge. Deasserting it mid-line always completes the line through LF.
- `start` persists across IDLE, so re-enabling continues the rotation.
- `data` value by state: `cur` in CHAR, 8'h0D in CR, 8'h0A in LF, and `cur` (don't-care) in IDLE.

## Timing
- Reset values, one edge after `n_rst`=0:
  - State IDLE, `valid_n`=1, `busy_n`=1.
  - `start`=`FIRST`, `cur`=`FIRST`, `col`=0, `line_no`=0, `data`=`FIRST`.
- Reset overrides everything, including a simultaneous transfer or `en_n`=0. A reset mid-line abandons the line; no CR LF is sent.
- All outputs are registered. From the edge that samples `en_n`=0 in IDLE, `valid_n`=0 and `data`=`start` are visible immediately after that edge (1-cycle start latency).
- Back-to-back operation:
  - On a transfer edge, the next byte is presented on the same edge and `valid_n` stays 0, so there are no bubbles when `ready_n` is held 0 (matches `uartout`'s overlapped read).
  - The LF→CHAR continuation is also bubble-free.
- One line occupies exactly `LINE_LEN`+2 transfers.
- `line_no` and `busy_n` change on the LF transfer edge.
- Stall: `ready_n`=1 for any number of cycles leaves `valid_n`, `data`, and the state unchanged.

## Test plan
- Reset, then `en_n`=0 with `ready_n`=0 held for 1 line:
  - Bytes are 0x20, 0x21 … 0x67 (72 bytes), then 0x0D, 0x0A.
  - `line_no`=1 after the LF.
  - 74 transfers occur in 74 consecutive cycles.
- Continuous run of 96 lines:
  - Line 1 starts 0x21.
  - Line 94 starts 0x7E, and its second byte is 0x20 (wrap).
  - Line 95 starts 0x20.
  - `line_no`=96 at the end.
- Random `ready_n` stalls (30% high) during a line:
  - `data` is stable while `valid_n`=0 and `ready_n`=1.
  - The transferred sequence equals the stall-free sequence.
- Raise `en_n` after byte 10 of line 0:
  - The line completes through 0x0A, then `valid_n`=1 and `busy_n`=1.
  - Lowering `en_n` again gives first byte 0x21.
- Assert `n_rst`=0 at byte 40 of line 2, coincident with a transfer:
  - Next edge: `valid_n`=1, `line_no`=0.
  - On re-enable, the first byte is 0x20.
- Drive the real `uartout` (CDIV=2):
  - The `tx` line decodes the first 3 bytes as 0x20, 0x21, 0x22, each framed by START=0 and STOP=1.
  - No idle gap between frames.
